cdc_wr_arb: RTL and testbench

Write-side arbiter for the CDC asynchronous FIFO. It shares one FIFO write port, in the `wclk` domain, between `NREQ` requesters using round-robin arbitration with burst locking. A granted requester keeps the port until its `last` beat is accepted, so bursts never interleave in the FIFO. Pushes are gated by the FIFO's registered `wfull`, so no beat is ever offered while the FIFO reports full.

---
 rtl/cdc_wr_arb_if.sv | 33 +++
 rtl/cdc_wr_arb.sv | 95 +++++++++
 tb/tb_cdc_wr_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_wr_arb_if.sv
// Bus bundle for cdc_wr_arb: requester handshakes plus the FIFO write port.
// Macro CDC_WR_ARB_ID_TAG_EN widens fifo_wdata to carry the requester tag.
interface cdc_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = $clog2(NREQ)
);
`ifdef CDC_WR_ARB_ID_TAG_EN
  localparam int FW = DW + IDW;
`else
  localparam int FW = DW;
`endif

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_wpush;
  logic [FW-1:0]      fifo_wdata;
  logic               fifo_wfull;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  modport slave (
    input  req_valid, req_last, req_data, fifo_wfull,
    output req_ready, fifo_wpush, fifo_wdata, grant_id, busy
  );

  modport master (
    output req_valid, req_last, req_data, fifo_wfull,
    input  req_ready, fifo_wpush, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/cdc_wr_arb.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port.
// Macro CDC_WR_ARB_ID_TAG_EN: fifo_wdata = {grant_id, data}; otherwise data only.
module cdc_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic         wclk,
  input  logic         wrst,
  cdc_wr_arb_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] w_grant_nxt;
  logic [IDW-1:0] w_pick;
  logic           w_found;
  logic           w_push;
  logic [DW-1:0]  w_data;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int step);
    int s;
    s = (int'(base) + step) % NREQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after the priority pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req_valid[wrap_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_idx(r_ptr, k);
      end
    end
  end

  assign w_push = (r_state == BURST) & bus.req_valid[r_grant] & ~bus.fifo_wfull;
  assign w_data = bus.req_data[int'(r_grant)*DW +: DW];

  always_comb begin
    bus.req_ready = '0;
    if (r_state == BURST && !bus.fifo_wfull)
      bus.req_ready[r_grant] = 1'b1;
  end

  assign bus.fifo_wpush = w_push;
`ifdef CDC_WR_ARB_ID_TAG_EN
  assign bus.fifo_wdata = {r_grant, w_data};
`else
  assign bus.fifo_wdata = w_data;
`endif
  assign bus.grant_id = r_grant;
  assign bus.busy     = (r_state == BURST);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BURST;
          w_grant_nxt = w_pick;
        end
      end
      BURST: begin
        // Grant is released only when the last beat actually transfers.
        if (w_push && bus.req_last[r_grant]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = wrap_idx(r_grant, 1);
        end
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

endmodule

// File: tb/tb_cdc_wr_arb.sv
// Directed bench for cdc_wr_arb: reset, round robin, burst lock, full stall,
// reset mid-burst and tag layout, with per-requester burst sources.
module tb_cdc_wr_arb;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  cdc_wr_arb_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

  cdc_wr_arb #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  typedef struct {
    int          tag;
    logic [31:0] d;
    logic        last;
    int          cyc;
  } ent_t;

  ent_t        log_q[$];
  int          m_len  [NREQ];
  int          m_blen [NREQ];
  logic        m_auto [NREQ];
  logic        m_hold [NREQ];
  logic [31:0] m_base [NREQ];
  logic [31:0] m_seq  [NREQ];
  logic        m_full;
  logic        m_rst;
  logic [NREQ-1:0] hs;
  int          cyc;
  int          checks;
  int          errors;
  int          c0;
  int          cf;
  logic [63:0] exp_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = (m_len[i] > 0) && !m_hold[i];
      bus.req_last[i]           = (m_len[i] == 1);
      bus.req_data[i*DW +: DW]  = m_base[i] + m_seq[i];
    end
    bus.fifo_wfull = m_full;
    wrst           = m_rst;
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 4ns after the edge.
  task automatic tick();
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        m_len[i]--;
        m_seq[i]++;
        if (m_len[i] == 0 && m_auto[i]) m_len[i] = m_blen[i];
      end
    end
    drive();
    #3;
    hs = wrst ? '0 : (bus.req_valid & bus.req_ready);
    if (!wrst && bus.fifo_wpush)
      log_q.push_back('{int'(bus.grant_id), bus.fifo_wdata[DW-1:0],
                        bus.req_last[bus.grant_id], cyc});
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      m_len[i]  = 0;
      m_blen[i] = 0;
      m_auto[i] = 1'b0;
      m_hold[i] = 1'b0;
      m_seq[i]  = '0;
      m_base[i] = 32'(i) << 28;
    end
    m_full = 1'b0;
  endtask

  task automatic reset_phase();
    m_rst = 1'b1;
    tick();
    tick();
    clear_model();
    log_q.delete();
    m_rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    hs     = '0;
    m_rst  = 1'b1;
    clear_model();
    for (int i = 0; i < NREQ; i++) begin
      m_len[i]  = 2;
      m_blen[i] = 2;
      m_auto[i] = 1'b1;
    end
    drive();

    // Reset held with every requester valid
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rst_wpush", 64'(bus.fifo_wpush), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_grant", 64'(bus.grant_id), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
    end
    m_rst = 1'b0;
    tick();
    c0 = cyc;
    chk("idle_wpush", 64'(bus.fifo_wpush), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // Round robin, 2-beat bursts from all four
    for (int n = 0; n < 40 && log_q.size() < 9; n++) tick();
    chk("rr_count", 64'(log_q.size() >= 9), 64'd1);
    chk("rr_first_lat", 64'(log_q[0].cyc), 64'(c0 + 1));
    chk("rr_t0", 64'(log_q[0].tag), 64'd0);
    chk("rr_d0", 64'(log_q[0].d), 64'h0000_0000);
    chk("rr_t1", 64'(log_q[1].tag), 64'd0);
    chk("rr_last1", 64'(log_q[1].last), 64'd1);
    chk("rr_t2", 64'(log_q[2].tag), 64'd1);
    chk("rr_d2", 64'(log_q[2].d), 64'h1000_0000);
    chk("rr_bubble", 64'(log_q[2].cyc - log_q[1].cyc), 64'd2);
    chk("rr_t4", 64'(log_q[4].tag), 64'd2);
    chk("rr_d5", 64'(log_q[5].d), 64'h2000_0001);
    chk("rr_t6", 64'(log_q[6].tag), 64'd3);
    chk("rr_d7", 64'(log_q[7].d), 64'h3000_0001);
    chk("rr_t8", 64'(log_q[8].tag), 64'd0);
    chk("rr_d8", 64'(log_q[8].d), 64'h0000_0002);
    chk("rr_round", 64'(log_q[8].cyc - log_q[0].cyc), 64'd12);

    // Burst lock: requester 2 holds the port through a valid gap
    reset_phase();
    m_len[2] = 4;
    tick();
    m_len[1] = 2;
    for (int n = 0; n < 20 && log_q.size() < 2; n++) tick();
    m_hold[2] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("lock_ready", 64'(bus.req_ready), 64'b0100);
      chk("lock_wpush", 64'(bus.fifo_wpush), 64'd0);
      chk("lock_grant", 64'(bus.grant_id), 64'd2);
    end
    m_hold[2] = 1'b0;
    for (int n = 0; n < 20 && log_q.size() < 6; n++) tick();
    chk("lock_count", 64'(log_q.size()), 64'd6);
    for (int k = 0; k < 4; k++) begin
      chk("lock_tag2", 64'(log_q[k].tag), 64'd2);
      chk("lock_d2", 64'(log_q[k].d), 64'(32'h2000_0000 + 32'(k)));
    end
    chk("lock_last2", 64'(log_q[3].last), 64'd1);
    chk("lock_tag1", 64'(log_q[4].tag), 64'd1);
    chk("lock_d1", 64'(log_q[5].d), 64'h1000_0001);

    // Full stall with the last beat pending
    reset_phase();
    m_len[0] = 3;
    for (int n = 0; n < 20 && log_q.size() < 2; n++) tick();
    m_full = 1'b1;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("full_wpush", 64'(bus.fifo_wpush), 64'd0);
      chk("full_ready", 64'(bus.req_ready), 64'd0);
      chk("full_busy", 64'(bus.busy), 64'd1);
    end
    m_full = 1'b0;
    cf = cyc;
    for (int n = 0; n < 10 && log_q.size() < 3; n++) tick();
    for (int r = 0; r < 3; r++) tick();
    chk("full_count", 64'(log_q.size()), 64'd3);
    chk("full_d0", 64'(log_q[0].d), 64'h0000_0000);
    chk("full_d1", 64'(log_q[1].d), 64'h0000_0001);
    chk("full_d2", 64'(log_q[2].d), 64'h0000_0002);
    chk("full_last", 64'(log_q[2].last), 64'd1);
    chk("full_after", 64'(log_q[2].cyc > cf), 64'd1);
    chk("full_idle", 64'(bus.busy), 64'd0);

    // Reset while requester 3 presents beat 3 of 8
    reset_phase();
    m_len[3] = 8;
    for (int n = 0; n < 20 && log_q.size() < 2; n++) tick();
    chk("mid_grant3", 64'(bus.grant_id), 64'd3);
    m_rst    = 1'b1;
    m_len[0] = 2;
    tick();
    m_rst = 1'b0;
    tick();
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_grant", 64'(bus.grant_id), 64'd0);
    chk("mid_wpush", 64'(bus.fifo_wpush), 64'd0);
    tick();
    chk("mid_regrant", 64'(bus.grant_id), 64'd0);
    chk("mid_busy2", 64'(bus.busy), 64'd1);
    chk("mid_ready", 64'(bus.req_ready), 64'b0001);

    // Tag layout on fifo_wdata
    reset_phase();
    m_base[1] = 32'hDEAD_BEEF;
    m_len[1]  = 1;
    tick();
    tick();
`ifdef CDC_WR_ARB_ID_TAG_EN
    exp_wdata = 64'({2'b01, 32'hDEAD_BEEF});
`else
    exp_wdata = 64'h0000_0000_DEAD_BEEF;
`endif
    chk("tag_grant", 64'(bus.grant_id), 64'd1);
    chk("tag_wpush", 64'(bus.fifo_wpush), 64'd1);
    chk("tag_wdata", 64'(bus.fifo_wdata), exp_wdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
